dot_accum: RTL and testbench
============================

# dot_accum

Fixed-point dot-product accumulator directly downstream of the N-lane 45-bit multiplier array in the inverse-kinematics datapath. Each beat takes the N rounded products, sums them in a registered adder stage, and accumulates across beats until a beat flagged `in_last`. The 45-bit result is saturated and held in an output register under a valid/ready handshake. `in_ready` also drives the multiplier array's clock enable, so the whole multiply–accumulate pipe stalls as one unit.

## Interface
- `N`, 3: product lanes per beat; must match the multiplier array; 1..4.
- `W`, 45: product and result width, signed two's complement, 22 fractional bits (1.0 = 0x400000).
- `MAX_BEATS`, 64: maximum beats per dot product.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_data` and `in_last` are valid.
- `in_last` in 1: this beat ends the current dot product.
- `in_data` in N×W: packed products, lane 0 in the LSBs.
- `in_ready` out 1: beat is accepted when `in_valid && in_ready`; also drives the multiplier clken.
- `out_valid` out 1: result is held in the output register.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out W: saturated dot product.
- `out_sat` out 1: `out_data` was clamped.
- `out_trunc` out 1: dot product was force-terminated at `MAX_BEATS`.
- `out_beats` out 7: number of beats in this result, 1..64.

## Operation
- Internal accumulator width AW = W+8. With N≤4 and ≤64 beats the accumulator cannot overflow. No internal saturation.
- Stall condition: `stall = out_valid && !out_ready`. `in_ready = !stall`.
- While stalled, stage S1, the accumulator, the beat counter and the output register all hold.
- **Stage S1** (on accept):
  - `s1_sum` = sign-extended sum of the N lanes, AW bits.
  - `s1_last` = `in_last || (cnt == MAX_BEATS-1)`.
  - `s1_trunc` = `!in_last && cnt == MAX_BEATS-1`.
  - `s1_valid` is set on accept and cleared otherwise (when not stalled).
- **Accumulate** (when `s1_valid && !stall`):
  - `acc_next = (first ? 0 : acc) + s1_sum`.
  - If `!s1_last`: `acc <= acc_next`, `first <= 0`, `cnt <= cnt+1`.
  - If `s1_last`:
    - `out_data <= sat_W(acc_next)`.
    - `out_sat <= (acc_next` outside `[-2^(W-1), 2^(W-1)-1])`.
    - `out_trunc <= s1_trunc`, `out_beats <= cnt+1`, `out_valid <= 1`.
    - `first <= 1`, `cnt <= 0`.
- Counter `cnt` counts beats entering S1 in the current product and is used at accept time to tag `s1_last`. It increments on accept and clears when a last beat is accepted.
- **Output register:**
  - `out_valid` clears on `out_valid && out_ready` unless a new result loads in the same cycle.
  - A same-cycle load takes priority: `out_valid` stays 1 with the new data.
- Saturation: clamp to 0x0FFF_FFFF_FFFF (max) or 0x1000_0000_0000 (min, W=45).
- State view: IDLE (`first=1`, nothing in S1) → ACCUM (partial sum held) → RESULT (`out_valid=1`) → back to IDLE/ACCUM on handshake.
  - RESULT with `out_ready=0` is the STALL state.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sat=0`, `out_trunc=0`, `out_beats=0`, `s1_valid=0`, `acc=0`, `first=1`, `cnt=0`.
- Reset mid-operation discards any partial sum and any held result.
- Latency: a last beat accepted at cycle t gives `out_valid=1` at t+2, with no stall.
- Throughput: one beat per cycle while `out_ready` is high.
- Back-to-back single-beat products with `out_ready=1` produce one result per cycle.
- `out_data`, `out_sat`, `out_trunc` and `out_beats` are stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_valid` and `out_ready` only; there is no path from `in_valid`.
- Beats offered while `in_ready=0` are not consumed; upstream holds them.
- The `MAX_BEATS`-th beat without `in_last` ends the product with `out_trunc=1`. The next beat starts a new product.

## Test plan
- **Single beat:** one beat with `in_last=1`, lanes {0x400000, 0x800000, −0x200000} (1.0, 2.0, −0.5) → at t+2, `out_data=0xA00000`, `out_beats=1`, `out_sat=0`.
- **Multi-beat:** three consecutive beats of {0x400000, 0x400000, 0x400000}, last on the third → one result `out_data=0x2400000` (9.0), `out_beats=3`; no `out_valid` before the last beat.
- **Saturation:** one beat of three lanes 0x0FFF_FFFF_FFFF with last → `out_data=0x0FFF_FFFF_FFFF`, `out_sat=1`. Three lanes 0x1000_0000_0000 → `out_data=0x1000_0000_0000`, `out_sat=1`.
- **Backpressure:** result held with `out_ready=0` for 5 cycles while `in_valid=1` → `in_ready=0` and outputs unchanged during those cycles. The next result matches the golden model after release, with no lost or duplicated beats.
- **Truncation:** 70 beats of {1, 0, 0} with no `in_last` → first result `out_data=64`, `out_beats=64`, `out_trunc=1`. The next 6 beats continue into a new product.
- **Reset mid-product:** 2 beats of {0x400000, 0, 0}, then `reset` for 1 cycle, then 1 beat {0x400000, 0, 0} with last → `out_data=0x400000`, `out_beats=1`.

Source files
------------

// File: rtl/dot_accum.sv
// Dot-product accumulator behind the N-lane multiplier array. Sums lanes per beat,
// accumulates across beats, saturates the result and holds it under valid/ready.
//
// state  | meaning (implicit in first / s1_valid / out_valid)
// IDLE   | first=1, no beat in S1, no partial sum
// ACCUM  | partial sum held in acc (first=0)
// RESULT | out_valid=1, result held in the output register
// STALL  | RESULT with out_ready=0; whole pipe including the multiplier array holds
module dot_accum #(
  parameter int N         = 3,
  parameter int W         = 45,
  parameter int MAX_BEATS = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [N*W-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_sat,
  output logic           out_trunc,
  output logic [6:0]     out_beats
);

  // Eight guard bits cover up to 4 lanes x 64 beats, so acc never wraps.
  localparam int AW = W + 8;
  localparam logic [6:0] CNT_LAST = 7'(MAX_BEATS - 1);

  logic          stall;
  logic          accept;
  logic          at_max;
  logic [AW-1:0] lane_sum;

  logic          s1_valid;
  logic          s1_last;
  logic          s1_trunc;
  logic [AW-1:0] s1_sum;
  logic [6:0]    s1_beats;

  logic          first;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [6:0]    cnt;

  logic          ovf;
  logic [W-1:0]  sat_val;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign at_max   = (cnt == CNT_LAST);

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N; i++) begin
      lane_sum = lane_sum + {{(AW-W){in_data[i*W+W-1]}}, in_data[i*W +: W]};
    end
  end

  assign acc_next = (first ? '0 : acc) + s1_sum;

  // Fits in W bits only when the guard bits all match the W-bit sign bit.
  assign ovf     = !((&acc_next[AW-1:W-1]) || !(|acc_next[AW-1:W-1]));
  assign sat_val = acc_next[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_trunc  <= 1'b0;
      s1_sum    <= '0;
      s1_beats  <= '0;
      first     <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
      out_beats <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum   <= lane_sum;
        s1_last  <= in_last || at_max;
        s1_trunc <= !in_last && at_max;
        s1_beats <= cnt + 7'd1;
        cnt      <= (in_last || at_max) ? 7'd0 : cnt + 7'd1;
      end

      if (s1_valid && !s1_last) begin
        acc   <= acc_next;
        first <= 1'b0;
      end

      // A new result takes priority over the handshake clearing out_valid.
      if (s1_valid && s1_last) begin
        out_valid <= 1'b1;
        out_data  <= ovf ? sat_val : acc_next[W-1:0];
        out_sat   <= ovf;
        out_trunc <= s1_trunc;
        out_beats <= s1_beats;
        first     <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: directed cases plus randomized products checked against
// an arithmetic reference model (whole-product sums, then clamp).
module tb_dot_accum;

  localparam int N = 3;
  localparam int W = 45;
  localparam int MAXB = 64;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    logic         t;
    logic [6:0]   b;
  } res_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_last;
  logic [N*W-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_sat;
  logic           out_trunc;
  logic [6:0]     out_beats;

  dot_accum #(.N(N), .W(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_trunc(out_trunc), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-product arithmetic on signed 64-bit integers.
  res_t   exp_q[$];
  res_t   got_q[$];
  longint part = 0;
  int     nb   = 0;

  function automatic longint lane_val(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic res_t make_res(input longint s, input bit trunc, input int beats);
    longint mx = (longint'(1) <<< (W-1)) - 1;
    longint mn = -(longint'(1) <<< (W-1));
    longint c;
    res_t r;
    c = (s > mx) ? mx : ((s < mn) ? mn : s);
    r.d = c[W-1:0];
    r.s = (s > mx) || (s < mn);
    r.t = trunc;
    r.b = 7'(beats);
    return r;
  endfunction

  bit   held_stall = 0;
  res_t held;

  always @(negedge clk) begin
    if (reset) begin
      part = 0;
      nb = 0;
      exp_q.delete();
      held_stall = 0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (held_stall) begin
        chk("stall_data", out_data, held.d);
        chk("stall_sat", out_sat, held.s);
        chk("stall_trunc", out_trunc, held.t);
        chk("stall_beats", out_beats, held.b);
        chk("stall_valid", out_valid, 1);
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N; i++) part += lane_val(in_data[i*W +: W]);
        nb++;
        if (in_last || nb == MAXB) begin
          exp_q.push_back(make_res(part, !in_last, nb));
          part = 0;
          nb = 0;
        end
      end
      if (out_valid && out_ready) begin
        res_t g;
        g.d = out_data; g.s = out_sat; g.t = out_trunc; g.b = out_beats;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("spurious_result", out_valid, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_data", out_data, e.d);
          chk("res_sat", out_sat, e.s);
          chk("res_trunc", out_trunc, e.t);
          chk("res_beats", out_beats, e.b);
        end
      end
      held_stall = out_valid && !out_ready;
      held.d = out_data; held.s = out_sat; held.t = out_trunc; held.b = out_beats;
    end
  end

  bit rnd_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_beat(input logic [W-1:0] l0, input logic [W-1:0] l1,
                           input logic [W-1:0] l2, input logic last);
    int k;
    in_valid = 1'b1;
    in_data  = {l2, l1, l0};
    in_last  = last;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    rnd_ready = 0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin
      k++;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] one_q, neg_half, vmax, vmin, rl0, rl1, rl2;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    one_q = 45'h400000;
    neg_half = -45'sh200000;
    vmax = 45'h0FFF_FFFF_FFFF;
    vmin = 45'h1000_0000_0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_trunc", out_trunc, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single beat with latency check.
    got_q.delete();
    send_beat(one_q, 45'h800000, neg_half, 1'b1);
    @(negedge clk);
    chk("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", out_valid, 1);
    chk("single_data", out_data, 45'hA00000);
    chk("single_beats", out_beats, 1);
    chk("single_sat", out_sat, 0);
    drain();

    // Multi-beat: no result before the last beat.
    got_q.delete();
    send_beat(one_q, one_q, one_q, 1'b0);
    send_beat(one_q, one_q, one_q, 1'b0);
    @(negedge clk);
    chk("multi_early_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send_beat(one_q, one_q, one_q, 1'b1);
    drain();
    chk("multi_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("multi_data", got_q[0].d, 45'h2400000);
      chk("multi_beats", got_q[0].b, 3);
    end

    // Saturation both directions.
    got_q.delete();
    send_beat(vmax, vmax, vmax, 1'b1);
    send_beat(vmin, vmin, vmin, 1'b1);
    drain();
    chk("sat_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("sat_hi_data", got_q[0].d, 45'h0FFF_FFFF_FFFF);
      chk("sat_hi_flag", got_q[0].s, 1);
      chk("sat_lo_data", got_q[1].d, 45'h1000_0000_0000);
      chk("sat_lo_flag", got_q[1].s, 1);
    end

    // Backpressure: result held, next beat refused for 5 cycles.
    got_q.delete();
    out_ready = 1'b0;
    send_beat(one_q, 45'd0, 45'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = {45'd0, one_q, one_q};
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, 45'h400000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    drain();
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("bp_first", got_q[0].d, 45'h400000);
      chk("bp_second", got_q[1].d, 45'h800000);
    end

    // Truncation at MAX_BEATS, remainder starts a new product.
    got_q.delete();
    for (int i = 0; i < 70; i++) send_beat(45'd1, 45'd0, 45'd0, 1'b0);
    send_beat(45'd1, 45'd0, 45'd0, 1'b1);
    drain();
    chk("trunc_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("trunc_data", got_q[0].d, 64);
      chk("trunc_beats", got_q[0].b, 64);
      chk("trunc_flag", got_q[0].t, 1);
      chk("trunc_next_data", got_q[1].d, 7);
      chk("trunc_next_beats", got_q[1].b, 7);
      chk("trunc_next_flag", got_q[1].t, 0);
    end

    // Reset mid-product discards the partial sum.
    send_beat(one_q, 45'd0, 45'd0, 1'b0);
    send_beat(one_q, 45'd0, 45'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    send_beat(one_q, 45'd0, 45'd0, 1'b1);
    drain();
    chk("rstmid_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("rstmid_data", got_q[0].d, 45'h400000);
      chk("rstmid_beats", got_q[0].b, 1);
    end

    // Randomized products with random backpressure and gaps.
    rnd_ready = 1;
    for (int p = 0; p < 120; p++) begin
      int len;
      int mode;
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 68) : $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      for (int b = 0; b < len; b++) begin
        if (mode == 0) begin
          rl0 = 45'($signed($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000);
          rl1 = 45'($signed($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000);
          rl2 = 45'($signed($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000);
        end else begin
          rl0 = {$urandom, $urandom};
          rl1 = {$urandom, $urandom};
          rl2 = (mode == 1) ? {13'h0FFF, $urandom} : {$urandom, $urandom};
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(rl0, rl1, rl2, (b == len - 1));
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
